// File: rtl/mlp_pkg.sv
// Shared types and helpers for the folded MLP layer scheduler.
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Weight ROM / activation RAM read latency, and MAC accumulate latency.
  localparam int MEM_RD_LAT = 1;
  localparam int MAC_LAT    = 1;

  // Bits needed to index v items, never fewer than one.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/mlp_layer_scheduler_if.sv
// Start/done handshake plus memory and MAC strobes of the MLP scheduler.
interface mlp_layer_scheduler_if import mlp_pkg::*; #(
  parameter int M = 3,
  parameter int N = 2
);
  localparam int NW = clog2_min1(N);
  localparam int WW = clog2_min1(M * N * N);
  localparam int LW = clog2_min1(M);

  logic          start;
  logic          hold;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [WW-1:0] w_addr;
  logic [NW-1:0] x_addr;
  logic          x_bank;
  logic          mac_en;
  logic          mac_clr;
  logic          y_wr_en;
  logic [NW-1:0] y_addr;
  logic          y_bank;
  logic [LW-1:0] layer;
  logic          res_bank;

  // Host / controller side.
  modport master (
    output start, hold,
    input  busy, done, rd_en, w_addr, x_addr, x_bank, mac_en, mac_clr,
           y_wr_en, y_addr, y_bank, layer, res_bank
  );

  // Scheduler side.
  modport slave (
    input  start, hold,
    output busy, done, rd_en, w_addr, x_addr, x_bank, mac_en, mac_clr,
           y_wr_en, y_addr, y_bank, layer, res_bank
  );

endinterface

// File: rtl/mlp_idx_counter.sv
// Nested layer (l) / neuron (j) / input (i) index counter for the folded MLP sweep.
module mlp_idx_counter import mlp_pkg::*; #(
  parameter int M = 3,
  parameter int N = 2
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        en_i,
  input  logic                        clr_ji_i,
  input  logic                        inc_l_i,
  input  logic                        clr_l_i,
  output logic [clog2_min1(M)-1:0]    l_o,
  output logic [clog2_min1(N)-1:0]    j_o,
  output logic [clog2_min1(N)-1:0]    i_o,
  output logic                        i_last_o,
  output logic                        j_last_o,
  output logic                        l_last_o
);
  localparam int NW = clog2_min1(N);
  localparam int LW = clog2_min1(M);

  logic [NW-1:0] i_q, i_d;
  logic [NW-1:0] j_q, j_d;
  logic [LW-1:0] l_q, l_d;

  assign i_last_o = (i_q == NW'(N - 1));
  assign j_last_o = (j_q == NW'(N - 1));
  assign l_last_o = (l_q == LW'(M - 1));
  assign i_o      = i_q;
  assign j_o      = j_q;
  assign l_o      = l_q;

  // Next index: i is innermost, j wraps with i, l only moves on explicit request.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    l_d = l_q;
    if (clr_ji_i) begin
      i_d = NW'(0);
      j_d = NW'(0);
    end else if (en_i) begin
      if (i_last_o) begin
        i_d = NW'(0);
        if (j_last_o) begin
          j_d = NW'(0);
        end else begin
          j_d = j_q + NW'(1);
        end
      end else begin
        i_d = i_q + NW'(1);
      end
    end else begin
      i_d = i_q;
    end
    if (clr_l_i) begin
      l_d = LW'(0);
    end else if (inc_l_i) begin
      l_d = l_q + LW'(1);
    end else begin
      l_d = l_q;
    end
  end

  // Index registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      i_q <= NW'(0);
      j_q <= NW'(0);
      l_q <= LW'(0);
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      l_q <= l_d;
    end
  end

endmodule

// File: rtl/mlp_layer_scheduler.sv
// Sequences an M-layer, N-wide MLP onto one shared MAC with ping-pong activation banks.
module mlp_layer_scheduler import mlp_pkg::*; #(
  parameter int M = 3,
  parameter int N = 2
) (
  input logic                  clk,
  input logic                  nrst,
  mlp_layer_scheduler_if.slave bus
);
  localparam int NW     = clog2_min1(N);
  localparam int WW     = clog2_min1(M * N * N);
  localparam int LW     = clog2_min1(M);
  // Reads retire into the MAC after MEM_RD_LAT; the finished sum is written MAC_LAT later.
  localparam int WB_LAT = MEM_RD_LAT + MAC_LAT;

  typedef struct packed {
    logic          en;
    logic          first;
    logic          last;
    logic [NW-1:0] j;
    logic          bank;
  } pipe_t;

  sched_state_t  state_q, state_d;
  logic          drain_q, drain_d;
  pipe_t         pipe_q [WB_LAT];
  pipe_t         pipe_d [WB_LAT];

  logic [LW-1:0] l_s;
  logic [NW-1:0] j_s, i_s;
  logic          i_last_s, j_last_s, l_last_s;
  logic          cnt_en_s, clr_ji_s, inc_l_s, clr_l_s;
  logic          rd_s;

  mlp_idx_counter #(.M(M), .N(N)) u_idx (
    .clk      (clk),
    .nrst     (nrst),
    .en_i     (cnt_en_s),
    .clr_ji_i (clr_ji_s),
    .inc_l_i  (inc_l_s),
    .clr_l_i  (clr_l_s),
    .l_o      (l_s),
    .j_o      (j_s),
    .i_o      (i_s),
    .i_last_o (i_last_s),
    .j_last_o (j_last_s),
    .l_last_o (l_last_s)
  );

  assign rd_s = (state_q == RUN) && !bus.hold;

  // Next state and index-counter controls; hold suppresses every transition.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    cnt_en_s = 1'b0;
    clr_ji_s = 1'b0;
    inc_l_s  = 1'b0;
    clr_l_s  = 1'b0;
    if (bus.hold) begin
      state_d = state_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (i_last_s && j_last_s) begin
            clr_ji_s = 1'b1;
            drain_d  = 1'b0;
            state_d  = DRAIN;
          end else begin
            cnt_en_s = 1'b1;
          end
        end
        DRAIN: begin
          if (!drain_q) begin
            drain_d = 1'b1;
          end else if (l_last_s) begin
            state_d = DONE;
          end else begin
            inc_l_s = 1'b1;
            state_d = RUN;
          end
        end
        DONE: begin
          clr_l_s = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Control FSM registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Delay pipe: stage 0 tags each read; later stages keep only neuron-completing reads.
  always_comb begin
    pipe_d = pipe_q;
    if (bus.hold) begin
      pipe_d = pipe_q;
    end else begin
      if (rd_s) begin
        pipe_d[0].en    = 1'b1;
        pipe_d[0].first = (i_s == NW'(0));
        pipe_d[0].last  = i_last_s;
        pipe_d[0].j     = j_s;
        pipe_d[0].bank  = ~l_s[0];
      end else begin
        pipe_d[0] = '0;
      end
      for (int k = 1; k < WB_LAT; k++) begin
        if ((k >= MEM_RD_LAT) && !(pipe_q[k-1].en && pipe_q[k-1].last)) begin
          pipe_d[k] = '0;
        end else begin
          pipe_d[k] = pipe_q[k-1];
        end
      end
    end
  end

  // Delay pipe registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < WB_LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < WB_LAT; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE) && !bus.hold;
  assign bus.rd_en    = rd_s;
  assign bus.w_addr   = WW'(l_s) * WW'(N * N) + WW'(j_s) * WW'(N) + WW'(i_s);
  assign bus.x_addr   = i_s;
  assign bus.x_bank   = l_s[0];
  assign bus.mac_en   = pipe_q[MEM_RD_LAT-1].en && !bus.hold;
  assign bus.mac_clr  = pipe_q[MEM_RD_LAT-1].en && pipe_q[MEM_RD_LAT-1].first && !bus.hold;
  assign bus.y_wr_en  = pipe_q[WB_LAT-1].en && pipe_q[WB_LAT-1].last && !bus.hold;
  assign bus.y_addr   = pipe_q[WB_LAT-1].j;
  assign bus.y_bank   = pipe_q[WB_LAT-1].bank;
  assign bus.layer    = l_s;
  assign bus.res_bank = 1'(M % 2);

endmodule

// File: tb/tb_mlp_layer_scheduler.sv
// Scoreboard bench for mlp_layer_scheduler (M=3,N=2 randomized, plus an M=1,N=1 instance).
module tb_mlp_layer_scheduler;
  import mlp_pkg::*;

  localparam int M       = 3;
  localparam int N       = 2;
  localparam int RUN_LEN = M * (N * N + 2) + 1;

  typedef struct packed { int off; int w; int x; int xb; int ly; } rd_rec_t;
  typedef struct packed { int off; int clr; } mac_rec_t;
  typedef struct packed { int off; int y; int yb; } wr_rec_t;

  logic clk;
  logic nrst;

  mlp_layer_scheduler_if #(.M(M), .N(N)) bus0 ();
  mlp_layer_scheduler_if #(.M(1), .N(1)) bus1 ();

  mlp_layer_scheduler #(.M(M), .N(N)) dut0 (.clk(clk), .nrst(nrst), .bus(bus0.slave));
  mlp_layer_scheduler #(.M(1), .N(1)) dut1 (.clk(clk), .nrst(nrst), .bus(bus1.slave));

  rd_rec_t  rd_q[$];
  mac_rec_t mac_q[$];
  wr_rec_t  wr_q[$];
  int       done_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int seen_acc = 0;
  int act = 0;
  int done_cyc = -1;
  bit acc1 = 1'b0;
  int t1 = 0;
  bit finish_req = 1'b0;
  bit fin_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: on an accepted start, enqueue every event of the inference,
  // tagged with its offset in un-held cycles after the accepting edge.
  always @(posedge clk) begin : model
    int off;
    if (nrst && bus0.start && !bus0.hold && (acc_cnt == done_cnt) && (done_cyc != cyc)) begin
      off = 1;
      for (int l = 0; l < M; l++) begin
        for (int j = 0; j < N; j++) begin
          for (int i = 0; i < N; i++) begin
            rd_q.push_back('{off, l * N * N + j * N + i, i, l % 2, l});
            mac_q.push_back('{off + 1, (i == 0) ? 1 : 0});
            if (i == N - 1) wr_q.push_back('{off + 2, j, 1 - (l % 2)});
            off++;
          end
        end
        off += 2;
      end
      done_q.push_back(RUN_LEN);
      acc_cnt++;
    end
    if (nrst && bus1.start && !acc1) begin
      acc1 = 1'b1;
      t1 = cyc;
    end
    cyc++;
  end

  // Monitor: pops expected events whenever the DUT presents one.
  always @(negedge clk) begin : monitor
    rd_rec_t  ra, re;
    mac_rec_t ma, me;
    wr_rec_t  wa, we;
    int       de, k;
    logic [8:0] a1, e1;
    if (!nrst) begin
      total++;
      if (bus0.busy || bus0.done || bus0.rd_en || bus0.mac_en || bus0.mac_clr || bus0.y_wr_en ||
          (bus0.w_addr != '0) || (bus0.x_addr != '0) || bus0.x_bank || (bus0.y_addr != '0) ||
          bus0.y_bank || (bus0.layer != '0) || !bus0.res_bank) begin
        bad++;
        $display("FAIL reset_outputs: busy=%0b done=%0b rd=%0b mac=%0b clr=%0b wr=%0b w=%0d x=%0d xb=%0b y=%0d yb=%0b layer=%0d res_bank=%0b; want all 0, res_bank=1",
                 bus0.busy, bus0.done, bus0.rd_en, bus0.mac_en, bus0.mac_clr, bus0.y_wr_en, bus0.w_addr,
                 bus0.x_addr, bus0.x_bank, bus0.y_addr, bus0.y_bank, bus0.layer, bus0.res_bank);
      end
      rd_q.delete();
      mac_q.delete();
      wr_q.delete();
      done_q.delete();
      done_cnt = acc_cnt;
      seen_acc = acc_cnt;
    end else begin
      if (acc_cnt != seen_acc) begin
        seen_acc = acc_cnt;
        act = 0;
      end
      if ((acc_cnt != done_cnt) && !bus0.hold) act++;

      total++;
      if (bus0.busy !== (acc_cnt != done_cnt)) begin
        bad++;
        $display("FAIL busy: cyc=%0d got=%0b want=%0b", cyc, bus0.busy, acc_cnt != done_cnt);
      end
      if (bus0.hold) begin
        total++;
        if (bus0.rd_en || bus0.mac_en || bus0.y_wr_en || bus0.done) begin
          bad++;
          $display("FAIL hold_strobes: cyc=%0d rd=%0b mac=%0b wr=%0b done=%0b, want all 0",
                   cyc, bus0.rd_en, bus0.mac_en, bus0.y_wr_en, bus0.done);
        end
      end
      if (bus0.rd_en) begin
        total++;
        ra = '{act, int'(bus0.w_addr), int'(bus0.x_addr), int'(bus0.x_bank), int'(bus0.layer)};
        if (rd_q.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected: cyc=%0d w=%0d", cyc, ra.w);
        end else begin
          re = rd_q.pop_front();
          if (ra != re) begin
            bad++;
            $display("FAIL rd: got off=%0d w=%0d x=%0d xb=%0d layer=%0d want off=%0d w=%0d x=%0d xb=%0d layer=%0d",
                     ra.off, ra.w, ra.x, ra.xb, ra.ly, re.off, re.w, re.x, re.xb, re.ly);
          end
        end
      end
      if (bus0.mac_en) begin
        total++;
        ma = '{act, int'(bus0.mac_clr)};
        if (mac_q.size() == 0) begin
          bad++;
          $display("FAIL mac_unexpected: cyc=%0d", cyc);
        end else begin
          me = mac_q.pop_front();
          if (ma != me) begin
            bad++;
            $display("FAIL mac: got off=%0d clr=%0d want off=%0d clr=%0d", ma.off, ma.clr, me.off, me.clr);
          end
        end
      end
      if (bus0.y_wr_en) begin
        total++;
        wa = '{act, int'(bus0.y_addr), int'(bus0.y_bank)};
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL wr_unexpected: cyc=%0d", cyc);
        end else begin
          we = wr_q.pop_front();
          if (wa != we) begin
            bad++;
            $display("FAIL wr: got off=%0d y=%0d yb=%0d want off=%0d y=%0d yb=%0d",
                     wa.off, wa.y, wa.yb, we.off, we.y, we.yb);
          end
        end
      end
      if (bus0.done) begin
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: cyc=%0d", cyc);
        end else begin
          de = done_q.pop_front();
          if (act != de) begin
            bad++;
            $display("FAIL done_latency: got=%0d want=%0d", act, de);
          end
          done_cnt++;
          done_cyc = cyc;
        end
      end

      k = acc1 ? (cyc - t1) : 0;
      case (k)
        1:       e1 = 9'b1_1100_0000;
        2:       e1 = 9'b1_1011_0000;
        3:       e1 = 9'b1_1000_1100;
        4:       e1 = 9'b1_1000_0001;
        default: e1 = 9'b1_0000_0000;
      endcase
      a1 = {bus1.res_bank, bus1.busy, bus1.rd_en, bus1.mac_en, bus1.mac_clr,
            bus1.y_wr_en, bus1.y_bank, bus1.y_addr, bus1.done};
      total++;
      if (a1 !== e1) begin
        bad++;
        $display("FAIL m1n1: cycle=%0d got=%b want=%b (res_bank,busy,rd,mac,clr,wr,yb,y,done)", k, a1, e1);
      end

      if (finish_req && !fin_done) begin
        fin_done = 1'b1;
        total++;
        if ((rd_q.size() != 0) || (mac_q.size() != 0) || (wr_q.size() != 0) ||
            (done_q.size() != 0) || !acc1) begin
          bad++;
          $display("FAIL leftover: rd=%0d mac=%0d wr=%0d done=%0d m1n1_started=%0b, want 0 0 0 0 1",
                   rd_q.size(), mac_q.size(), wr_q.size(), done_q.size(), acc1);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus0.start = 1'b1;
    step(1);
    bus0.start = 1'b0;
  endtask

  // Stimulus: directed scenarios followed by randomized start/hold traffic.
  initial begin
    nrst = 1'b0;
    bus0.start = 1'b0;
    bus0.hold = 1'b0;
    bus1.start = 1'b0;
    bus1.hold = 1'b0;
    step(3);
    nrst = 1'b1;
    step(2);

    // Plain inference.
    pulse_start();
    step(24);

    // Hold for three cycles in the middle of layer 1.
    pulse_start();
    step(7);
    bus0.hold = 1'b1;
    step(3);
    bus0.hold = 1'b0;
    step(22);

    // Second start while busy is ignored.
    pulse_start();
    step(8);
    pulse_start();
    step(20);

    // Reset mid-inference, then a full run.
    pulse_start();
    step(7);
    nrst = 1'b0;
    step(1);
    nrst = 1'b1;
    step(1);
    pulse_start();
    step(24);

    // Randomized start/hold, including start+hold together while idle.
    for (int c = 0; c < 600; c++) begin
      bus0.start = ($urandom_range(0, 5) == 0);
      bus0.hold  = ($urandom_range(0, 4) == 0);
      step(1);
    end
    bus0.start = 1'b0;
    bus0.hold = 1'b0;
    step(40);

    // Degenerate M=1, N=1 instance.
    bus1.start = 1'b1;
    step(1);
    bus1.start = 1'b0;
    step(8);

    finish_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
